// File: rtl/filter_seq_ctrl_if.sv
// filter_seq_ctrl_if
//   Groups the sequencer's control inputs and datapath-control outputs.
//   master : the side that issues en / sample_tick / ovr_clr and observes the
//            strobes (a testbench or a surrounding filter top level).
//   slave  : the sequencer itself (filter_seq_ctrl).
//   Signals
//     en, sample_tick, ovr_clr          master -> slave
//     in_ld, mac_clr, mac_en, tap_idx,
//     shift_en, out_ld, done, busy,
//     overrun, sample_cnt               slave -> master
interface filter_seq_ctrl_if #(
  parameter int AW = 3,
  parameter int CW = 16
);
  logic          en;
  logic          sample_tick;
  logic          ovr_clr;
  logic          in_ld;
  logic          mac_clr;
  logic          mac_en;
  logic [AW-1:0] tap_idx;
  logic          shift_en;
  logic          out_ld;
  logic          done;
  logic          busy;
  logic          overrun;
  logic [CW-1:0] sample_cnt;

  modport master (
    output en, sample_tick, ovr_clr,
    input  in_ld, mac_clr, mac_en, tap_idx, shift_en, out_ld, done, busy,
           overrun, sample_cnt
  );

  modport slave (
    input  en, sample_tick, ovr_clr,
    output in_ld, mac_clr, mac_en, tap_idx, shift_en, out_ld, done, busy,
           overrun, sample_cnt
  );
endinterface

// File: rtl/filter_seq_ctrl.sv
// filter_seq_ctrl
//   Moore sequencer for a time-multiplexed FIR filter. Each accepted sample
//   tick walks IDLE -> LOAD -> MAC (N_TAPS cycles) -> SHIFT -> OUT -> IDLE,
//   driving the load / clear / accumulate / shift strobes of the datapath.
//   Ticks that arrive while a sample is in flight are dropped and recorded in
//   a sticky overrun flag.
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : filter_seq_ctrl_if.slave (en, sample_tick, ovr_clr in;
//            in_ld, mac_clr, mac_en, tap_idx, shift_en, out_ld, done, busy,
//            overrun, sample_cnt out)
//   Parameters
//     N_TAPS : taps per sample, 2..2**AW
//     AW     : tap index width
//     CW     : completed-sample counter width (wraps modulo 2**CW)
module filter_seq_ctrl #(
  parameter int N_TAPS = 5,
  parameter int AW     = 3,
  parameter int CW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  filter_seq_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    SHIFT,
    OUT
  } state_t;

  localparam logic [AW-1:0] LAST_TAP = AW'(N_TAPS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q;
  logic          ovr_q;
  logic          busy;

  // State and tap index register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and tap-index logic. The index is forced back to 0 when MAC
  // exits, so the registered value itself reads 0 in every other state.
  // NOTE: every signal is given a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.sample_tick && bus.en) state_d = LOAD;
      end
      LOAD: begin
        idx_d   = '0;
        state_d = MAC;
      end
      MAC: begin
        if (idx_q == LAST_TAP) begin
          idx_d   = '0;
          state_d = SHIFT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SHIFT: state_d = OUT;
      OUT:   state_d = IDLE;
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  // Completed-sample counter advances on the edge that leaves OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == OUT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Sticky overrun: a tick seen while busy (including the OUT cycle) sets it;
  // set takes priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (bus.sample_tick && busy) begin
      ovr_q <= 1'b1;
    end else if (bus.ovr_clr) begin
      ovr_q <= 1'b0;
    end
  end

  // Moore outputs decoded from registered state only.
  assign bus.in_ld      = (state_q == LOAD);
  assign bus.mac_clr    = (state_q == LOAD);
  assign bus.mac_en     = (state_q == MAC);
  assign bus.tap_idx    = idx_q;
  assign bus.shift_en   = (state_q == SHIFT);
  assign bus.out_ld     = (state_q == OUT);
  assign bus.done       = (state_q == OUT);
  assign bus.busy       = busy;
  assign bus.overrun    = ovr_q;
  assign bus.sample_cnt = cnt_q;

endmodule

// File: doc/filter_seq_ctrl.md
FILTER_SEQ_CTRL -- requirements
Module: filter_seq_ctrl

Interface
REQ-001 SHALL have parameter N_TAPS, default 5: number of filter taps processed per sample; legal range 2..(2**AW).
REQ-002 SHALL have parameter AW, default 3: width of the tap/coefficient index.
REQ-003 SHALL have parameter CW, default 16: width of the processed-sample counter.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  sequencer enable; sampled only in IDLE.
REQ-007 sample_tick  input  1  one-cycle pulse requesting processing of a new input sample.
REQ-008 ovr_clr  input  1  clears the sticky overrun flag.
REQ-009 in_ld  output  1  load enable for the filter input sample register.
REQ-010 mac_clr  output  1  synchronous clear of the accumulator register.
REQ-011 mac_en  output  1  accumulate enable for the multiply-accumulate datapath.
REQ-012 tap_idx  output  AW  coefficient address and delay-line tap select.
REQ-013 shift_en  output  1  advance enable for the delay-line registers.
REQ-014 out_ld  output  1  load enable for the filter output register.
REQ-015 done  output  1  one-cycle pulse marking that the output register is updated.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 overrun  output  1  sticky flag: a sample_tick arrived while busy.
REQ-018 sample_cnt  output  CW  count of completed samples.

Function
REQ-019 SHALL implement a Moore FSM with states IDLE, LOAD, MAC, SHIFT and OUT; all outputs are registered or decoded from registered state only.
REQ-020 IDLE: if sample_tick=1 and en=1, next state SHALL be LOAD; otherwise remain IDLE.
REQ-021 LOAD (1 cycle): in_ld=1 and mac_clr=1; tap index counter SHALL load 0; next state MAC.
REQ-022 MAC (N_TAPS cycles): mac_en=1 and tap_idx=index counter; the counter SHALL increment each cycle.
REQ-023 MAC SHALL exit to SHIFT in the cycle where tap_idx=N_TAPS-1; tap_idx SHALL never exceed N_TAPS-1.
REQ-024 SHIFT (1 cycle): shift_en=1; next state OUT.
REQ-025 OUT (1 cycle): out_ld=1 and done=1; sample_cnt SHALL increment by 1 (modulo 2**CW, wrapping to 0); next state IDLE.
REQ-026 With a tick accepted at edge k, LOAD SHALL occupy cycle k+1, MAC cycles k+2..k+N_TAPS+1, SHIFT k+N_TAPS+2 and OUT k+N_TAPS+3; busy is high for exactly N_TAPS+3 cycles.
REQ-027 Outside its own state, each of in_ld, mac_clr, mac_en, shift_en, out_ld and done SHALL be 0; tap_idx SHALL hold 0 outside MAC.
REQ-028 A sample_tick while busy=1 SHALL be ignored for sequencing and SHALL set overrun=1.
REQ-029 ovr_clr SHALL clear overrun on the next edge; if it coincides with a setting tick, set SHALL win.
REQ-030 Deasserting en while busy SHALL NOT abort; the current sample completes and en gates only the next IDLE acceptance.
REQ-031 A sample_tick arriving in the OUT cycle counts as overrun and is not queued; a tick in the first IDLE cycle after OUT is accepted.

Reset
REQ-032 While rst=1: state IDLE, tap_idx=0, sample_cnt=0, overrun=0, busy=0 and all enables/done=0, regardless of clk.
REQ-033 Reset asserted mid-sequence SHALL abort immediately with no further enable pulses; after release, the block waits in IDLE for a new tick.

Verification
REQ-034 N_TAPS=5, en=1, single tick at edge 10 -> in_ld/mac_clr at 11, mac_en with tap_idx 0,1,2,3,4 at 12-16, shift_en at 17, out_ld/done at 18, sample_cnt=1, busy for 8 cycles.
REQ-035 Tick at edge 10 and second tick at edge 14 -> second tick ignored, overrun=1 from edge 15, sample_cnt=1 after the sequence; ovr_clr pulse -> overrun=0.
REQ-036 en=0 with a tick -> state stays IDLE, no enables, sample_cnt unchanged; en dropped during MAC -> sequence completes with done.
REQ-037 rst pulsed during MAC at tap_idx=2 -> all outputs 0 immediately, sample_cnt=0; next tick runs a full clean sequence.
REQ-038 CW=4, 16 back-to-back legal ticks spaced N_TAPS+4 cycles apart -> sample_cnt wraps 15->0, overrun stays 0.
REQ-039 Simultaneous ovr_clr and a busy-time tick -> overrun remains 1.
